stream_pack: RTL
================

STREAM_PACK -- requirements
Module: stream_pack

Interface
REQ-001 SHALL have no parameters; input width 64, output width 1024, 16 words per output beat are fixed.
REQ-002 clk  in  1  sole clock; all state changes on its rising edge.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 s_valid  in  1  input word valid.
REQ-005 s_data  in  64  input word.
REQ-006 s_last  in  1  final word of packet.
REQ-007 s_ready  out  1  input word accepted when s_valid&s_ready.
REQ-008 m_valid  out  1  output beat valid; drives downstream S_AXIS_TVALID.
REQ-009 m_data  out  1024  output beat; word k occupies bits [64k+63:64k].
REQ-010 m_last  out  1  output beat closes packet.
REQ-011 m_ready  in  1  downstream accepts when m_valid&m_ready.
REQ-012 out_cnt  out  16  emitted-beat counter; present only with STREAM_PACK_STAT_EN.

Function
REQ-013 SHALL hold an assembly buffer (16x64), lane counter cnt (0..15), an output register and a two-state FSM FILL/HOLD.
REQ-014 FILL: s_ready=1; accepted word written to lane cnt, cnt increments.
REQ-015 Beat completes on accepting a word with cnt==15 or s_last=1.
REQ-016 On completion, if output register empty or handshaking this cycle, SHALL load it (including the completing word) and assert m_valid next cycle; cnt<=0, buffer cleared, stay FILL.
REQ-017 Otherwise SHALL go HOLD with the completed beat kept in the buffer.
REQ-018 HOLD: s_ready=0; on output handshake, buffer moves to output register next cycle, cnt<=0, buffer cleared, return FILL.
REQ-019 Lanes above the completing lane SHALL be zero in m_data (short-packet padding).
REQ-020 m_last SHALL equal s_last of the completing word.
REQ-021 Latency: m_valid rises the cycle after the completing input handshake when output free.
REQ-022 m_valid, m_data, m_last SHALL stay stable while m_valid&~m_ready.
REQ-023 m_valid clears after handshake unless a new beat loads the same cycle (back-to-back allowed).
REQ-024 s_last with cnt==0 SHALL emit a beat with only lane 0 set.
REQ-025 Sustained throughput: one input word per cycle while m_ready=1.

Reset
REQ-026 rst SHALL immediately force FILL, cnt=0, buffer and output register zero, m_valid=0, m_last=0, s_ready=1 after release.
REQ-027 rst mid-packet or mid-HOLD SHALL discard all partial and pending data.

Configuration
REQ-028 Macro STREAM_PACK_STAT_EN defined: out_cnt increments per output handshake, saturates at 16'hFFFF, reset 0.
REQ-029 Macro absent: out_cnt port and counter do not exist; all other behaviour identical.

Verification
REQ-030 32 words 0..31, m_ready=1 -> two beats; beat0 lane k=k, beat1 lane k=16+k; m_last=0 for both.
REQ-031 5 words 0xA0..0xA4, last on 5th -> one beat, lanes 0..4 set, lanes 5..15 zero, m_last=1.
REQ-032 m_ready=0, 32 words -> beat0 held stable, s_ready drops after 32nd word (HOLD); m_ready=1 -> beat0 then beat1 out, s_ready=1.
REQ-033 rst pulse after 7 words of a packet -> m_valid=0, next 16 words form a clean beat with no residue.
REQ-034 STREAM_PACK_STAT_EN, 3 beats emitted -> out_cnt=3; 65537 beats -> out_cnt=16'hFFFF.

Source files
------------

// File: rtl/stream_pack.sv
// Packs 64-bit stream words into 1024-bit beats of 16 lanes; short packets are zero-padded.
// Optional STREAM_PACK_STAT_EN adds a saturating out_cnt of emitted beats.
module stream_pack (
  input  logic          clk,
  input  logic          rst,
  input  logic          s_valid,
  input  logic [63:0]   s_data,
  input  logic          s_last,
  output logic          s_ready,
  output logic          m_valid,
  output logic [1023:0] m_data,
  output logic          m_last,
  input  logic          m_ready
`ifdef STREAM_PACK_STAT_EN
  ,
  output logic [15:0]   out_cnt
`endif
);

  typedef enum logic {FILL, HOLD} state_t;

  state_t        state;
  logic [3:0]    cnt;
  logic [1023:0] pack_buf;
  logic          hold_last;
  logic [1023:0] next_beat;
  logic          out_hs;
  logic          out_free;

  assign s_ready  = (state == FILL);
  assign out_hs   = m_valid & m_ready;
  assign out_free = ~m_valid | m_ready;

  // Buffer lanes above cnt are always zero, so this also yields the padded beat.
  always_comb begin
    next_beat = pack_buf;
    for (int unsigned k = 0; k < 16; k++) begin
      if (4'(k) == cnt) next_beat[64*k +: 64] = s_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= FILL;
      cnt       <= '0;
      pack_buf  <= '0;
      hold_last <= 1'b0;
      m_valid   <= 1'b0;
      m_data    <= '0;
      m_last    <= 1'b0;
    end else begin
      if (out_hs) m_valid <= 1'b0;
      case (state)
        FILL: begin
          if (s_valid) begin
            if (cnt == 4'd15 || s_last) begin
              if (out_free) begin
                m_data   <= next_beat;
                m_valid  <= 1'b1;
                m_last   <= s_last;
                pack_buf <= '0;
                cnt      <= '0;
              end else begin
                pack_buf  <= next_beat;
                hold_last <= s_last;
                state     <= HOLD;
              end
            end else begin
              pack_buf <= next_beat;
              cnt      <= cnt + 4'd1;
            end
          end
        end
        HOLD: begin
          if (out_hs) begin
            m_data   <= pack_buf;
            m_valid  <= 1'b1;
            m_last   <= hold_last;
            pack_buf <= '0;
            cnt      <= '0;
            state    <= FILL;
          end
        end
        default: state <= FILL;
      endcase
    end
  end

`ifdef STREAM_PACK_STAT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_cnt <= '0;
    end else if (out_hs && out_cnt != 16'hFFFF) begin
      out_cnt <= out_cnt + 16'd1;
    end
  end
`endif

endmodule
